// File: rtl/bcd_seg_scan.sv
// ============================================================================
// Module      : bcd_seg_scan
// Description : Multiplexed common-anode 7-segment scanner for packed BCD
//               digits, with inter-digit blanking and leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_seg_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;

    logic [4*NUM_DIGITS-1:0] shadow;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;

    logic [3:0]              cur_digit;
    logic                    cur_upper_zero;
    logic                    zero_run;
    logic                    lz_blank;
    logic [6:0]              seg_next;
    logic [NUM_DIGITS-1:0]   an_next;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    // Walk from the most significant digit down: zero_run stays set while every
    // digit from the top down to position i is zero.
    always_comb begin
        cur_digit      = 4'd0;
        cur_upper_zero = 1'b0;
        zero_run       = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (shadow[4*i +: 4] == 4'd0);
            if (idx == IDX_W'(i)) begin
                cur_digit      = shadow[4*i +: 4];
                cur_upper_zero = zero_run;
            end
        end
    end

    assign lz_blank = blank_lz && (idx != '0) && cur_upper_zero;

    always_comb begin
        seg_next = 7'h00;
        an_next  = AN_OFF;
        if (cnt != '0 && !lz_blank) begin
            seg_next = dec7(cur_digit);
            an_next  = ~(NUM_DIGITS'(1) << idx);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow <= '0;
            cnt    <= '0;
            idx    <= '0;
            seg    <= 7'h00;
            an     <= AN_OFF;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (load) begin
                shadow <= bcd_in;
            end
            seg <= seg_next;
            an  <= an_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bcd_seg_scan.sv
// ============================================================================
// Module      : tb_bcd_seg_scan
// Description : Directed self-checking bench for bcd_seg_scan (4 digits, div 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_seg_scan;

    logic        clk;
    logic        rst;
    logic [15:0] bcd_in;
    logic        load;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  an;

    int total = 0;
    int bad   = 0;
    bit in_reset_window = 1'b0;

    bcd_seg_scan #(
        .NUM_DIGITS(4),
        .SCAN_DIV  (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bcd_in  (bcd_in),
        .load    (load),
        .blank_lz(blank_lz),
        .seg     (seg),
        .an      (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Never more than one anode enabled.
    always @(negedge clk) begin
        check("an_onecold", 16'($countones(~an) <= 1), 16'd1);
    end

    // One full frame starting at an edge whose pre-edge state is idx0/cnt0.
    // segs packs the expected code per digit, [6:0] = digit 0; lit marks lit digits.
    task automatic run_frame(input string name, input logic do_load, input logic [15:0] val,
                             input logic blz, input logic [27:0] segs, input logic [3:0] lit);
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        blank_lz = blz;
        if (do_load) begin
            load   = 1'b1;
            bcd_in = val;
        end
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                load = 1'b0;
                if (c == 0 || !lit[d]) begin
                    exp_an  = 4'b1111;
                    exp_seg = 7'h00;
                end else begin
                    exp_an  = ~(4'b0001 << d);
                    exp_seg = segs[7*d +: 7];
                end
                check($sformatf("%s d%0d c%0d an", name, d, c), 16'(an), 16'(exp_an));
                check($sformatf("%s d%0d c%0d seg", name, d, c), 16'(seg), 16'(exp_seg));
            end
        end
    endtask

    initial begin
        rst      = 1'b0;
        bcd_in   = 16'h0000;
        load     = 1'b0;
        blank_lz = 1'b0;
        #12;
        check("reset an", 16'(an), 16'h000F);
        check("reset seg", 16'(seg), 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Digit codes for 4321: d0=06 d1=5B d2=4F d3=66.
        run_frame("t1_4321", 1'b1, 16'h4321, 1'b0, {7'h66, 7'h4F, 7'h5B, 7'h06}, 4'b1111);
        run_frame("t2_0007_lz", 1'b1, 16'h0007, 1'b1, {7'h3F, 7'h3F, 7'h3F, 7'h07}, 4'b0001);
        run_frame("t2_0007_nolz", 1'b0, 16'h0000, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h07}, 4'b1111);
        run_frame("t3_0500_lz", 1'b1, 16'h0500, 1'b1, {7'h3F, 7'h6D, 7'h3F, 7'h3F}, 4'b0111);
        run_frame("t4_FA98", 1'b1, 16'hFA98, 1'b0, {7'h40, 7'h40, 7'h6F, 7'h7F}, 4'b1111);
        run_frame("t5_1111", 1'b1, 16'h1111, 1'b0, {7'h06, 7'h06, 7'h06, 7'h06}, 4'b1111);

        // Reload at the edge where digit 1 is at cnt=2 (frame edge 7).
        blank_lz = 1'b0;
        for (int k = 0; k < 16; k++) begin
            logic [3:0] exp_an;
            logic [6:0] exp_seg;
            if (k == 6) begin
                load   = 1'b1;
                bcd_in = 16'h2222;
            end
            tick();
            load = 1'b0;
            if ((k % 4) == 0) begin
                exp_an  = 4'b1111;
                exp_seg = 7'h00;
            end else begin
                exp_an  = ~(4'b0001 << (k / 4));
                exp_seg = (k <= 6) ? 7'h06 : 7'h5B;
            end
            check($sformatf("t5_reload k%0d an", k), 16'(an), 16'(exp_an));
            check($sformatf("t5_reload k%0d seg", k), 16'(seg), 16'(exp_seg));
        end

        // Walk to idx=2/cnt=2, then assert reset between edges.
        for (int k = 0; k < 10; k++) tick();
        check("t6_pre an", 16'(an), 16'h000B);
        check("t6_pre seg", 16'(seg), 16'h005B);
        rst = 1'b0;
        #1;
        check("t6_async an", 16'(an), 16'h000F);
        check("t6_async seg", 16'(seg), 16'h0000);
        tick();
        check("t6_held an", 16'(an), 16'h000F);
        check("t6_held seg", 16'(seg), 16'h0000);
        rst = 1'b1;
        run_frame("t6_after", 1'b0, 16'h0000, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b1111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
